axi_lite_seq_master: RTL and testbench

Self-sequencing AXI4-Lite master used as a bus-exerciser for slave and VIP bring-up.
- After reset release it writes NUM_XFERS words to consecutive word addresses, then reads them all back.
- Compares each read against the expected value and reports DONE/ERROR flags.
- Has no command interface; sits directly on an AXI4-Lite slave port.

---
 rtl/axi_lite_pkg.sv | 27 ++
 rtl/axi_lite_wr_chan.sv | 67 ++++++
 rtl/axi_lite_seq_master.sv | 174 +++++++++++++++++
 tb/tb_axi_lite_seq_master.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_pkg.sv
// rtl/axi_lite_pkg.sv - shared AXI4-Lite constants, widths and sequencer state type
package axi_lite_pkg;

    localparam int AXI_ADDR_W = 32;
    localparam int AXI_DATA_W = 32;
    localparam int IDX_W      = 8;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WR      = 3'd1,
        ST_WR_RESP = 3'd2,
        ST_RD_ADDR = 3'd3,
        ST_RD_DATA = 3'd4,
        ST_FIN     = 3'd5
    } seq_state_t;

    // EXOKAY is illegal on AXI4-Lite, so anything other than OKAY counts as a failure
    function automatic logic resp_is_err(input logic [1:0] resp);
        return resp inside {RESP_EXOKAY, RESP_SLVERR, RESP_DECERR};
    endfunction

endpackage

// File: rtl/axi_lite_wr_chan.sv
// rtl/axi_lite_wr_chan.sv - AW/W channel driver with independent handshake tracking
module axi_lite_wr_chan #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                abort,
    input  logic [ADDR_W-1:0]   addr_in,
    input  logic [DATA_W-1:0]   data_in,
    output logic [ADDR_W-1:0]   awaddr,
    output logic                awvalid,
    input  logic                awready,
    output logic [DATA_W-1:0]   wdata,
    output logic [DATA_W/8-1:0] wstrb,
    output logic                wvalid,
    input  logic                wready,
    output logic                accepted
);

    logic aw_done_q;
    logic w_done_q;
    logic aw_hs;
    logic w_hs;

    assign aw_hs = awvalid && awready;
    assign w_hs  = wvalid && wready;

    // Either channel may complete first; both-accepted is reported on the cycle the later one lands
    assign accepted = (aw_done_q || aw_hs) && (w_done_q || w_hs);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            awaddr    <= '0;
            awvalid   <= 1'b0;
            wdata     <= '0;
            wstrb     <= '0;
            wvalid    <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (abort) begin
            awvalid   <= 1'b0;
            wvalid    <= 1'b0;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else if (start) begin
            awaddr    <= addr_in;
            wdata     <= data_in;
            wstrb     <= '1;
            awvalid   <= 1'b1;
            wvalid    <= 1'b1;
            aw_done_q <= 1'b0;
            w_done_q  <= 1'b0;
        end else begin
            if (aw_hs) begin
                awvalid   <= 1'b0;
                aw_done_q <= 1'b1;
            end
            if (w_hs) begin
                wvalid   <= 1'b0;
                w_done_q <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_lite_seq_master.sv
// rtl/axi_lite_seq_master.sv - self-sequencing AXI4-Lite write/readback exerciser (option: AXIL_SEQ_MASTER_TIMEOUT_EN)
module axi_lite_seq_master
    import axi_lite_pkg::*;
#(
    parameter int                 ADDR_W         = AXI_ADDR_W,
    parameter int                 DATA_W         = AXI_DATA_W,
    parameter logic [ADDR_W-1:0]  BASE_ADDR      = '0,
    parameter int                 NUM_XFERS      = 4,
    parameter logic [DATA_W-1:0]  DATA_SEED      = 32'hA5A5_0000,
    parameter int                 TIMEOUT_CYCLES = 1024
) (
    input  logic                ACLK,
    input  logic                ARESETn,
    output logic [ADDR_W-1:0]   M_AXI_AWADDR,
    output logic                M_AXI_AWVALID,
    input  logic                M_AXI_AWREADY,
    output logic [DATA_W-1:0]   M_AXI_WDATA,
    output logic [DATA_W/8-1:0] M_AXI_WSTRB,
    output logic                M_AXI_WVALID,
    input  logic                M_AXI_WREADY,
    input  logic [1:0]          M_AXI_BRESP,
    input  logic                M_AXI_BVALID,
    output logic                M_AXI_BREADY,
    output logic [ADDR_W-1:0]   M_AXI_ARADDR,
    output logic                M_AXI_ARVALID,
    input  logic                M_AXI_ARREADY,
    input  logic [DATA_W-1:0]   M_AXI_RDATA,
    input  logic [1:0]          M_AXI_RRESP,
    input  logic                M_AXI_RVALID,
    output logic                M_AXI_RREADY,
    output logic                DONE,
    output logic                ERROR
);

    seq_state_t          state_q, state_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                bready_q, arvalid_q, rready_q;
    logic [ADDR_W-1:0]   araddr_q;
    logic                done_q, error_q;
    logic                wr_start, wr_accepted;
    logic                b_hs, ar_hs, r_hs, last_idx;
    logic                resp_err, cmp_err, timeout_hit;

    function automatic logic [ADDR_W-1:0] xfer_addr(input logic [IDX_W-1:0] idx);
        return BASE_ADDR + (ADDR_W'(idx) << 2);
    endfunction

    function automatic logic [DATA_W-1:0] xfer_data(input logic [IDX_W-1:0] idx);
        return DATA_SEED + DATA_W'(idx);
    endfunction

    assign b_hs     = M_AXI_BVALID && bready_q;
    assign ar_hs    = arvalid_q && M_AXI_ARREADY;
    assign r_hs     = M_AXI_RVALID && rready_q;
    assign last_idx = (idx_q == IDX_W'(NUM_XFERS - 1));

    assign resp_err = (state_q == ST_WR_RESP && b_hs && resp_is_err(M_AXI_BRESP)) ||
                      (state_q == ST_RD_DATA && r_hs && resp_is_err(M_AXI_RRESP));
    assign cmp_err  = (state_q == ST_RD_DATA) && r_hs && (M_AXI_RDATA != xfer_data(idx_q));

`ifdef AXIL_SEQ_MASTER_TIMEOUT_EN
    logic [31:0] to_cnt_q;
    logic        busy;

    assign busy        = (state_q inside {ST_WR, ST_WR_RESP, ST_RD_ADDR, ST_RD_DATA});
    assign timeout_hit = busy && (to_cnt_q == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            to_cnt_q <= '0;
        end else if (state_d != state_q) begin
            to_cnt_q <= '0;
        end else if (busy) begin
            to_cnt_q <= to_cnt_q + 32'd1;
        end
    end
`else
    // Without the watchdog the master waits forever on a stalled slave
    assign timeout_hit = (TIMEOUT_CYCLES < 0);
`endif

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        unique case (state_q)
            ST_IDLE:    state_d = ST_WR;
            ST_WR:      if (wr_accepted) state_d = ST_WR_RESP;
            ST_WR_RESP: begin
                if (b_hs) begin
                    state_d = last_idx ? ST_RD_ADDR : ST_WR;
                    idx_d   = last_idx ? '0 : idx_q + 1'b1;
                end
            end
            ST_RD_ADDR: if (ar_hs) state_d = ST_RD_DATA;
            ST_RD_DATA: begin
                if (r_hs) begin
                    state_d = last_idx ? ST_FIN : ST_RD_ADDR;
                    idx_d   = last_idx ? idx_q : idx_q + 1'b1;
                end
            end
            ST_FIN:     state_d = ST_FIN;
            default:    state_d = ST_IDLE;
        endcase
        if (timeout_hit) begin
            state_d = ST_FIN;
            idx_d   = idx_q;
        end
    end

    assign wr_start = (state_d == ST_WR) && (state_q != ST_WR);

    // Handshake controls are registered from the next state, so they never combinationally follow slave signals
    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            idx_q     <= '0;
            bready_q  <= 1'b0;
            arvalid_q <= 1'b0;
            araddr_q  <= '0;
            rready_q  <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            idx_q     <= idx_d;
            bready_q  <= (state_d == ST_WR_RESP);
            arvalid_q <= (state_d == ST_RD_ADDR);
            rready_q  <= (state_d == ST_RD_DATA);
            if (state_d == ST_RD_ADDR && state_q != ST_RD_ADDR) begin
                araddr_q <= xfer_addr(idx_d);
            end
            if (state_d == ST_FIN) begin
                done_q <= 1'b1;
            end
            if (resp_err || cmp_err || timeout_hit) begin
                error_q <= 1'b1;
            end
        end
    end

    axi_lite_wr_chan #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wr_chan (
        .clk      (ACLK),
        .rst_n    (ARESETn),
        .start    (wr_start),
        .abort    (timeout_hit),
        .addr_in  (xfer_addr(idx_d)),
        .data_in  (xfer_data(idx_d)),
        .awaddr   (M_AXI_AWADDR),
        .awvalid  (M_AXI_AWVALID),
        .awready  (M_AXI_AWREADY),
        .wdata    (M_AXI_WDATA),
        .wstrb    (M_AXI_WSTRB),
        .wvalid   (M_AXI_WVALID),
        .wready   (M_AXI_WREADY),
        .accepted (wr_accepted)
    );

    assign M_AXI_BREADY  = bready_q;
    assign M_AXI_ARADDR  = araddr_q;
    assign M_AXI_ARVALID = arvalid_q;
    assign M_AXI_RREADY  = rready_q;
    assign DONE          = done_q;
    assign ERROR         = error_q;

endmodule

// File: tb/tb_axi_lite_seq_master.sv
// tb/tb_axi_lite_seq_master.sv - directed bench with a memory-mode AXI4-Lite slave model
module tb_axi_lite_seq_master;

    localparam int NX = 4;

    logic        ACLK;
    logic        ARESETn;
    logic [31:0] M_AXI_AWADDR;
    logic        M_AXI_AWVALID;
    logic        M_AXI_AWREADY;
    logic [31:0] M_AXI_WDATA;
    logic [3:0]  M_AXI_WSTRB;
    logic        M_AXI_WVALID;
    logic        M_AXI_WREADY;
    logic [1:0]  M_AXI_BRESP;
    logic        M_AXI_BVALID;
    logic        M_AXI_BREADY;
    logic [31:0] M_AXI_ARADDR;
    logic        M_AXI_ARVALID;
    logic        M_AXI_ARREADY;
    logic [31:0] M_AXI_RDATA;
    logic [1:0]  M_AXI_RRESP;
    logic        M_AXI_RVALID;
    logic        M_AXI_RREADY;
    logic        DONE;
    logic        ERROR;

    int n_checks = 0;
    int n_fail   = 0;

    int aw_delay      = 0;
    int bresp_err_idx = -1;
    int corrupt_idx   = -1;
    bit never_b       = 1'b0;

    int          aw_n, w_n, b_n, ar_n, r_n, ar_early, strb_bad;
    logic [31:0] aw_log [16];
    logic [31:0] w_log  [16];
    logic [31:0] ar_log [16];
    logic [31:0] mem    [16];

    int          aw_wait, aw_stall, aw_unstable, wv_cycles;
    logic [31:0] aw_hold;

    axi_lite_seq_master #(
        .TIMEOUT_CYCLES (16)
    ) dut (
        .ACLK          (ACLK),
        .ARESETn       (ARESETn),
        .M_AXI_AWADDR  (M_AXI_AWADDR),
        .M_AXI_AWVALID (M_AXI_AWVALID),
        .M_AXI_AWREADY (M_AXI_AWREADY),
        .M_AXI_WDATA   (M_AXI_WDATA),
        .M_AXI_WSTRB   (M_AXI_WSTRB),
        .M_AXI_WVALID  (M_AXI_WVALID),
        .M_AXI_WREADY  (M_AXI_WREADY),
        .M_AXI_BRESP   (M_AXI_BRESP),
        .M_AXI_BVALID  (M_AXI_BVALID),
        .M_AXI_BREADY  (M_AXI_BREADY),
        .M_AXI_ARADDR  (M_AXI_ARADDR),
        .M_AXI_ARVALID (M_AXI_ARVALID),
        .M_AXI_ARREADY (M_AXI_ARREADY),
        .M_AXI_RDATA   (M_AXI_RDATA),
        .M_AXI_RRESP   (M_AXI_RRESP),
        .M_AXI_RVALID  (M_AXI_RVALID),
        .M_AXI_RREADY  (M_AXI_RREADY),
        .DONE          (DONE),
        .ERROR         (ERROR)
    );

    initial begin
        ACLK = 1'b0;
        forever #5 ACLK = ~ACLK;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Handshake monitor: logs every accepted beat and keeps the slave memory
    always @(posedge ACLK) begin
        if (!ARESETn) begin
            aw_n <= 0; w_n <= 0; b_n <= 0; ar_n <= 0; r_n <= 0;
            ar_early <= 0; strb_bad <= 0;
            for (int k = 0; k < 16; k++) mem[k] <= '0;
        end else begin
            if (M_AXI_AWVALID && M_AXI_AWREADY) begin
                aw_log[aw_n % 16] <= M_AXI_AWADDR;
                aw_n <= aw_n + 1;
            end
            if (M_AXI_WVALID && M_AXI_WREADY) begin
                w_log[w_n % 16] <= M_AXI_WDATA;
                if (M_AXI_WSTRB !== 4'hF) strb_bad <= strb_bad + 1;
                w_n <= w_n + 1;
            end
            if (M_AXI_BVALID && M_AXI_BREADY) begin
                mem[aw_log[b_n % 16][5:2]] <= w_log[b_n % 16];
                b_n <= b_n + 1;
            end
            if (M_AXI_ARVALID && M_AXI_ARREADY) begin
                ar_log[ar_n % 16] <= M_AXI_ARADDR;
                if (b_n < NX) ar_early <= ar_early + 1;
                ar_n <= ar_n + 1;
            end
            if (M_AXI_RVALID && M_AXI_RREADY) r_n <= r_n + 1;
        end
    end

    // Slave responder: decides its outputs on the falling edge
    initial begin
        M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
        M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0; M_AXI_RRESP = 0;
        aw_wait = 0; aw_stall = 0; aw_unstable = 0; wv_cycles = 0; aw_hold = 0;
        forever begin
            @(negedge ACLK);
            if (!ARESETn) begin
                M_AXI_AWREADY = 0; M_AXI_WREADY = 0; M_AXI_BVALID = 0; M_AXI_BRESP = 0;
                M_AXI_ARREADY = 0; M_AXI_RVALID = 0; M_AXI_RDATA = 0;
                aw_wait = 0; aw_stall = 0; aw_unstable = 0; wv_cycles = 0;
            end else begin
                if (M_AXI_AWVALID) begin
                    if (aw_wait == 0) aw_hold = M_AXI_AWADDR;
                    else if (M_AXI_AWADDR !== aw_hold) aw_unstable++;
                    if (aw_wait >= aw_delay) M_AXI_AWREADY = 1;
                    else begin
                        M_AXI_AWREADY = 0;
                        aw_stall++;
                    end
                    aw_wait++;
                end else begin
                    M_AXI_AWREADY = 0;
                    aw_wait = 0;
                end
                M_AXI_WREADY = M_AXI_WVALID;
                if (M_AXI_WVALID) wv_cycles++;
                M_AXI_BVALID = (aw_n > b_n) && (w_n > b_n) && !never_b;
                M_AXI_BRESP  = (M_AXI_BVALID && b_n == bresp_err_idx) ? 2'b10 : 2'b00;
                M_AXI_ARREADY = M_AXI_ARVALID;
                M_AXI_RVALID  = (ar_n > r_n);
                if (!M_AXI_RVALID) M_AXI_RDATA = '0;
                else if (r_n == corrupt_idx) M_AXI_RDATA = 32'hDEAD_BEEF;
                else M_AXI_RDATA = mem[ar_log[r_n % 16][5:2]];
            end
        end
    end

    task automatic apply_reset(input int awd, input int berr, input int rcor, input bit nob);
        @(negedge ACLK);
        ARESETn = 1'b0;
        repeat (3) @(negedge ACLK);
        aw_delay = awd; bresp_err_idx = berr; corrupt_idx = rcor; never_b = nob;
        ARESETn = 1'b1;
    endtask

    task automatic wait_done(input string pfx);
        for (int c = 0; c < 2000 && !DONE; c++) @(negedge ACLK);
        check({pfx, "_done"}, DONE, 1'b1);
    endtask

    task automatic check_seq(input string pfx, input logic exp_err);
        check({pfx, "_error"}, ERROR, exp_err);
        check({pfx, "_aw_n"}, aw_n, NX);
        check({pfx, "_w_n"}, w_n, NX);
        check({pfx, "_b_n"}, b_n, NX);
        check({pfx, "_ar_n"}, ar_n, NX);
        check({pfx, "_r_n"}, r_n, NX);
        check({pfx, "_ar_early"}, ar_early, 0);
        check({pfx, "_strb"}, strb_bad, 0);
        for (int k = 0; k < NX; k++) begin
            check($sformatf("%s_awaddr%0d", pfx, k), aw_log[k], 32'(4 * k));
            check($sformatf("%s_wdata%0d", pfx, k), w_log[k], 32'hA5A5_0000 + 32'(k));
            check($sformatf("%s_araddr%0d", pfx, k), ar_log[k], 32'(4 * k));
        end
        check({pfx, "_fin_ctl"}, {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY,
                                  M_AXI_ARVALID, M_AXI_RREADY}, 5'b0);
    endtask

    initial begin
        ARESETn = 1'b0;
        repeat (3) @(negedge ACLK);
        check("rst_ctl", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                          M_AXI_RREADY, DONE, ERROR}, 7'b0);
        check("rst_addr", M_AXI_AWADDR | M_AXI_ARADDR | M_AXI_WDATA, 32'h0);
        check("rst_wstrb", M_AXI_WSTRB, 4'h0);

        ARESETn = 1'b1;
        @(negedge ACLK);
        check("first_aw", {M_AXI_AWVALID, M_AXI_WVALID}, 2'b11);
        check("first_awaddr", M_AXI_AWADDR, 32'h0);
        check("first_wdata", M_AXI_WDATA, 32'hA5A5_0000);
        wait_done("basic");
        check_seq("basic", 1'b0);

        apply_reset(3, -1, -1, 1'b0);
        wait_done("awdly");
        check_seq("awdly", 1'b0);
        check("awdly_stall", aw_stall, 3 * NX);
        check("awdly_unstable", aw_unstable, 0);
        check("awdly_wv_cycles", wv_cycles, NX);

        apply_reset(0, 1, -1, 1'b0);
        wait_done("bresp");
        check_seq("bresp", 1'b1);

        apply_reset(0, -1, 2, 1'b0);
        wait_done("rdcorrupt");
        check_seq("rdcorrupt", 1'b1);

        apply_reset(0, -1, -1, 1'b0);
        for (int c = 0; c < 200 && r_n < 1; c++) @(negedge ACLK);
        check("midrst_reach", r_n, 1);
        check("midrst_arvalid_pre", M_AXI_ARVALID, 1'b1);
        ARESETn = 1'b0;
        #1;
        check("midrst_ctl", {M_AXI_AWVALID, M_AXI_WVALID, M_AXI_BREADY, M_AXI_ARVALID,
                             M_AXI_RREADY, DONE, ERROR}, 7'b0);
        check("midrst_addr", M_AXI_AWADDR | M_AXI_ARADDR | M_AXI_WDATA, 32'h0);
        repeat (2) @(negedge ACLK);
        ARESETn = 1'b1;
        wait_done("midrst");
        check_seq("midrst", 1'b0);

`ifdef AXIL_SEQ_MASTER_TIMEOUT_EN
        begin
            int cyc;
            apply_reset(0, -1, -1, 1'b1);
            for (int c = 0; c < 200 && !M_AXI_BREADY; c++) @(negedge ACLK);
            check("to_bready_seen", M_AXI_BREADY, 1'b1);
            cyc = 0;
            for (int c = 0; c < 200 && !DONE; c++) begin
                @(negedge ACLK);
                cyc++;
            end
            check("to_cycles", cyc, 16);
            check("to_flags", {DONE, ERROR, M_AXI_BREADY}, 3'b110);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
